// File: rtl/simon_pkg.sv
// Shared constants, state type and round-constant helper for the Simon 128/128 key schedules.
package simon_pkg;

    localparam int unsigned W        = 64;
    localparam int unsigned N_RONDAS = 68;
    localparam int unsigned CNT_W    = 7;
    localparam int unsigned ZI_W     = 6;
    localparam int unsigned Z_LEN    = 62;

    localparam logic [W-1:0] C  = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [61:0]  Z2 = 62'b11001101101001111110001000010100011001001011000000111011110101;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        OUT
    } estado_t;

    // Round constant for sequence index idx (0..61).
    function automatic logic [W-1:0] rc(input logic [ZI_W-1:0] idx);
        return C ^ {{(W-1){1'b0}}, Z2[idx]};
    endfunction

endpackage

// File: rtl/simon_f_chave.sv
// Key-schedule mixing function f(x) = ror(x,3) ^ ror(x,4), purely combinational.
module simon_f_chave
    import simon_pkg::*;
(
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_f
);

    logic [W-1:0] w_ror3;
    logic [W-1:0] w_ror4;

    assign w_ror3 = {i_x[2:0], i_x[W-1:3]};
    assign w_ror4 = {i_x[3:0], i_x[W-1:4]};
    assign o_f    = w_ror3 ^ w_ror4;

endmodule

// File: rtl/simon_chave_inversa.sv
// Simon 128/128 reverse round-key generator: expands forward to k66/k67, then
// emits k67..k0 over valid/ready by running the schedule backwards.
module simon_chave_inversa
    import simon_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [127:0]     k0_i,
    input  logic             key_ready_i,
    output logic [W-1:0]     kj_o,
    output logic [CNT_W-1:0] ronda_o,
    output logic             key_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [ZI_W-1:0]  ZI_MAX      = ZI_W'(Z_LEN - 1);
    localparam logic [ZI_W-1:0]  ZI_OUT_INIT = ZI_W'((N_RONDAS - 3) % Z_LEN);
    localparam logic [CNT_W-1:0] CNT_EXP_END = CNT_W'(N_RONDAS - 3);
    localparam logic [CNT_W-1:0] CNT_TOP     = CNT_W'(N_RONDAS - 1);

    estado_t          r_estado, w_estado_n;
    logic [W-1:0]     r_ka, r_kb, w_ka_n, w_kb_n;
    logic [ZI_W-1:0]  r_zi, w_zi_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;

    logic [W-1:0]     r_kj, w_kj_n;
    logic [CNT_W-1:0] r_ronda, w_ronda_n;
    logic             r_valid, w_valid_n;
    logic             r_busy, w_busy_n;
    logic             r_done, w_done_n;

    logic [W-1:0]     w_f_fwd;
    logic [W-1:0]     w_f_inv;
    logic             w_aceite;

    simon_f_chave u_f_fwd (.i_x(r_kb), .o_f(w_f_fwd));
    simon_f_chave u_f_inv (.i_x(r_ka), .o_f(w_f_inv));

    assign w_aceite = r_valid && key_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= IDLE;
            r_ka     <= '0;
            r_kb     <= '0;
            r_zi     <= '0;
            r_cnt    <= '0;
            r_kj     <= '0;
            r_ronda  <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_estado <= w_estado_n;
            r_ka     <= w_ka_n;
            r_kb     <= w_kb_n;
            r_zi     <= w_zi_n;
            r_cnt    <= w_cnt_n;
            r_kj     <= w_kj_n;
            r_ronda  <= w_ronda_n;
            r_valid  <= w_valid_n;
            r_busy   <= w_busy_n;
            r_done   <= w_done_n;
        end
    end

    // Next state; outputs are derived from the next-state values so they register cleanly.
    always_comb begin
        w_estado_n = r_estado;
        w_ka_n     = r_ka;
        w_kb_n     = r_kb;
        w_zi_n     = r_zi;
        w_cnt_n    = r_cnt;
        w_done_n   = 1'b0;

        case (r_estado)
            IDLE: begin
                if (start_i) begin
                    w_ka_n     = k0_i[63:0];
                    w_kb_n     = k0_i[127:64];
                    w_zi_n     = '0;
                    w_cnt_n    = '0;
                    w_estado_n = EXPAND;
                end
            end
            EXPAND: begin
                w_ka_n  = r_kb;
                w_kb_n  = r_ka ^ w_f_fwd ^ rc(r_zi);
                w_zi_n  = (r_zi == ZI_MAX) ? '0 : r_zi + ZI_W'(1);
                w_cnt_n = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_EXP_END) begin
                    w_estado_n = OUT;
                    w_cnt_n    = CNT_TOP;
                    w_zi_n     = ZI_OUT_INIT;
                end
            end
            OUT: begin
                if (w_aceite) begin
                    // Inverse step: k[j-2] = k[j] ^ f(k[j-1]) ^ rc(j-2)
                    w_kb_n  = r_ka;
                    w_ka_n  = r_kb ^ w_f_inv ^ rc(r_zi);
                    w_zi_n  = (r_zi == '0) ? ZI_MAX : r_zi - ZI_W'(1);
                    w_cnt_n = r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        w_estado_n = IDLE;
                        w_cnt_n    = '0;
                        w_done_n   = 1'b1;
                    end
                end
            end
            default: begin
                w_estado_n = IDLE;
            end
        endcase

        w_valid_n = (w_estado_n == OUT);
        w_busy_n  = (w_estado_n != IDLE);
        w_kj_n    = w_valid_n ? w_kb_n  : '0;
        w_ronda_n = w_valid_n ? w_cnt_n : '0;
    end

    assign kj_o        = r_kj;
    assign ronda_o     = r_ronda;
    assign key_valid_o = r_valid;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

endmodule

// File: doc/simon_chave_inversa.md
# simon_chave_inversa

Reverse-order round-key generator for Simon 128/128 decryption. It loads the 128-bit master key and runs the forward key expansion internally until it reaches the last two round keys, k66 and k67. It then emits all 68 round keys in reverse order, k67 down to k0, over a valid/ready handshake. It feeds the decryption datapath in the same way the forward key schedule feeds the encryption datapath.

## Interface
- No parameters. Widths and constants are fixed by `simon_pkg`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_i` in 1: load `k0_i` and begin. Sampled only in IDLE.
- `k0_i` in 128: master key. Word k1 = [127:64], word k0 = [63:0].
- `key_ready_i` in 1: consumer accepts `kj_o` this cycle.
- `kj_o` out 64: current round key k[j].
- `ronda_o` out 7: index j of `kj_o`, 67 down to 0.
- `key_valid_o` out 1: `kj_o`/`ronda_o` valid.
- `busy_o` out 1: high in EXPAND and OUT.
- `done_o` out 1: one-cycle pulse after k0 is accepted.

## Operation
- Registers: `ka` and `kb` (64 bits each), `zi` (6 bits, mod-62 index into Z2), `cnt` (7 bits), state.
- f(x) = ror(x,3) ^ ror(x,4). Round constant rc(i) = C ^ {63'b0, Z2[i mod 62]}, with C = 64'hFFFF_FFFF_FFFF_FFFC.
- IDLE:
  - On `start_i`: ka ← k0_i[63:0], kb ← k0_i[127:64], zi ← 0, cnt ← 0, go to EXPAND.
  - `start_i` is ignored in every other state.
- EXPAND (66 cycles):
  - Each cycle: new = ka ^ f(kb) ^ rc(zi); ka ← kb; kb ← new; zi ← (zi == 61) ? 0 : zi + 1; cnt++.
  - On the step where cnt == 65: go to OUT, cnt ← 67, zi ← 3. At that point ka = k66 and kb = k67.
- OUT:
  - Drive `kj_o` = kb, `ronda_o` = cnt, `key_valid_o` = 1.
  - On `key_valid_o && key_ready_i` (accept):
    - kb ← ka.
    - ka ← kb ^ f(ka) ^ rc(zi). This is the inverse step k[j-2] = k[j] ^ f(k[j-1]) ^ rc(j-2).
    - zi ← (zi == 0) ? 61 : zi - 1.
    - cnt--.
  - On accept with cnt == 0: go to IDLE and pulse `done_o`. The ka value computed on this accept is don't-care.
- No accept means the state holds and `kj_o`/`ronda_o` stay stable. `key_valid_o` never drops until the accept.
- All arithmetic is XOR/rotate on 64-bit words. The index wraps 0↔61 in both directions.

## Timing
- Reset values: `kj_o` = 0, `ronda_o` = 0, `key_valid_o` = 0, `busy_o` = 0, `done_o` = 0. State = IDLE.
- In IDLE, `kj_o` and `ronda_o` read 0.
- `start_i` sampled at edge E0. Expansion steps occur at edges E1..E66. `key_valid_o` is high after E66, so the first key appears 66 cycles after start.
- With `key_ready_i` tied high: one key per cycle, k0 accepted 67 cycles after the first key, and `done_o` high the cycle after the final accept.
- `busy_o` rises after E0 and falls together with the `done_o` pulse.
- Reset asserted mid-EXPAND or mid-OUT: return to IDLE immediately and force all outputs to reset values. No partial output after release.
- A `start_i` during the `done_o` cycle is accepted, since the state is already IDLE.

## Structure
- `simon_pkg` holds:
  - `C`.
  - `Z2` = 62'b11001101101001111110001000010100011001001011000000111011110101, where bit i is sequence element i.
  - `N_RONDAS` = 68.
  - `W` = 64.
  - The state enum `{IDLE, EXPAND, OUT}`.
- The forward key schedule imports the same package.
- Sub-module `simon_f_chave`: combinational f(x), 64 bits in and 64 bits out. It is instantiated twice, once for the forward step and once for the inverse step, and is shareable with the forward schedule.

## Test plan
- Key 0x0f0e0d0c0b0a0908_0706050403020100, ready high:
  - First valid 66 cycles after start with `ronda_o` = 67.
  - The 68 keys must equal the team forward-schedule model in reverse.
  - Last two keys: k1 = 0x0f0e0d0c0b0a0908, then k0 = 0x0706050403020100.
  - `done_o` pulses once.
- Random `key_ready_i` backpressure (30% high): key sequence identical to the previous run. `kj_o`/`ronda_o` stable while valid and not ready.
- `start_i` pulsed during EXPAND and during OUT: ignored, output sequence unchanged.
- `rst_n` dropped at EXPAND step 30 and at OUT j = 40: outputs go to 0 immediately. A fresh start afterwards produces the correct full sequence.
- Key all-zero and key all-ones: reverse sequence matches the model, exercising the `zi` wrap at 0↔61 during the j = 62..0 range.
- Back-to-back: new `start_i` in the `done_o` cycle with a different key. The second sequence is correct, with no stale key from the first run.
